// File: rtl/top_wb.sv
// MIPS write-back stage: latches MEM/WB, selects ALU/load/link data and drives the
// register-file write port; clears r1..r31 after reset and freezes on HALT.
module top_wb #(
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_ADDR      = 11,
  parameter int CANT_BITS_LOAD_TYPE = 3
) (
  input  logic                               i_clock,
  input  logic                               i_soft_reset,
  input  logic                               i_enable,
  input  logic                               i_valid,
  input  logic                               i_RegWrite,
  input  logic                               i_MemtoReg,
  input  logic                               i_link,
  input  logic                               i_halt,
  input  logic [$clog2(CANT_REGISTROS)-1:0]  i_reg_write,
  input  logic [CANT_BITS_REGISTROS-1:0]     i_alu_result,
  input  logic [CANT_BITS_REGISTROS-1:0]     i_mem_data,
  input  logic [CANT_BITS_LOAD_TYPE-1:0]     i_load_type,
  input  logic [CANT_BITS_ADDR-1:0]          i_pc_link,
  output logic                               o_control_write_reg,
  output logic [$clog2(CANT_REGISTROS)-1:0]  o_reg_write,
  output logic [CANT_BITS_REGISTROS-1:0]     o_data_write,
  output logic                               o_busy,
  output logic                               o_halted,
  output logic [31:0]                        o_retired_count
);

  localparam int AW = $clog2(CANT_REGISTROS);
  localparam int W  = CANT_BITS_REGISTROS;
  localparam logic [AW-1:0] LAST_IDX = AW'(CANT_REGISTROS - 1);
  localparam logic [CANT_BITS_LOAD_TYPE-1:0] LT_LH  = CANT_BITS_LOAD_TYPE'(1);
  localparam logic [CANT_BITS_LOAD_TYPE-1:0] LT_LHU = CANT_BITS_LOAD_TYPE'(2);
  localparam logic [CANT_BITS_LOAD_TYPE-1:0] LT_LB  = CANT_BITS_LOAD_TYPE'(3);
  localparam logic [CANT_BITS_LOAD_TYPE-1:0] LT_LBU = CANT_BITS_LOAD_TYPE'(4);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALTED} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           we_q, we_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic [31:0]    count_q, count_d;

  logic           capture;
  logic           sweep;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [W-1:0]   load_data;
  logic [W-1:0]   sel_data;

  always_comb begin
    lane_b = i_mem_data[8*i_alu_result[1:0] +: 8];
    lane_h = i_mem_data[16*i_alu_result[1] +: 16];
    case (i_load_type)
      LT_LB:   load_data = {{(W-8){lane_b[7]}}, lane_b};
      LT_LBU:  load_data = {{(W-8){1'b0}}, lane_b};
      LT_LH:   load_data = {{(W-16){lane_h[15]}}, lane_h};
      LT_LHU:  load_data = {{(W-16){1'b0}}, lane_h};
      default: load_data = i_mem_data;
    endcase
    if (i_link)          sel_data = {{(W-CANT_BITS_ADDR){1'b0}}, i_pc_link};
    else if (i_MemtoReg) sel_data = load_data;
    else                 sel_data = i_alu_result;
  end

  assign capture = i_enable & i_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    case (state_q)
      ST_INIT: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (capture) begin
          we_d    = i_RegWrite & (i_reg_write != '0);
          waddr_d = i_reg_write;
          wdata_d = sel_data;
          count_d = count_q + 32'd1;
          if (i_halt) state_d = ST_HALTED;
        end
      end
      ST_HALTED: ;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      state_q <= ST_INIT;
      idx_q   <= AW'(1);
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

  // Sweep writes are driven straight from the index so INIT spans exactly 31 cycles;
  // they are masked while reset is held so the port stays quiet during reset.
  assign sweep = (state_q == ST_INIT) & ~i_soft_reset;

  assign o_control_write_reg = sweep | we_q;
  assign o_reg_write         = sweep ? idx_q : waddr_q;
  assign o_data_write        = sweep ? '0 : wdata_q;
  assign o_busy              = (state_q == ST_INIT);
  assign o_halted            = (state_q == ST_HALTED);
  assign o_retired_count     = count_q;

endmodule

// File: doc/top_wb.md
# top_wb

Write-back stage of the MIPS pipeline and the driver of the register-file write port consumed by the instruction-decode stage. It latches the MEM/WB pipeline register and selects ALU result, aligned/extended load data, or link address. It issues one registered write per retired instruction and counts retired instructions. After reset, a sequencer clears registers 1..31 before normal operation; on a halt instruction the stage freezes so the debug unit can read the counters.

## Interface
- CANT_REGISTROS, 32, number of architectural registers; address width = clogb2(CANT_REGISTROS-1)
- CANT_BITS_REGISTROS, 32, register/data width
- CANT_BITS_ADDR, 11, PC/link address width
- CANT_BITS_LOAD_TYPE, 3, load-type code width

Ports:
- i_clock  in  1  single clock, all logic on rising edge
- i_soft_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline advance (debug step / run); 0 = hold
- i_valid  in  1  MEM stage holds a real instruction (0 = bubble)
- i_RegWrite  in  1  instruction writes a register
- i_MemtoReg  in  1  1 = load data, 0 = ALU result
- i_link  in  1  JAL/JALR; write data = link address (overrides i_MemtoReg)
- i_halt  in  1  instruction is HALT
- i_reg_write  in  5  destination register
- i_alu_result  in  32  ALU result; bits [1:0] are the load byte offset
- i_mem_data  in  32  raw data-memory word
- i_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others treated as LW
- i_pc_link  in  11  return address
- o_control_write_reg  out  1  register-file write enable
- o_reg_write  out  5  register-file write address
- o_data_write  out  32  register-file write data
- o_busy  out  1  clear sweep in progress; upstream must stall
- o_halted  out  1  HALT has retired
- o_retired_count  out  32  instructions retired since reset

## Operation
- States: INIT, RUN, HALTED. Reset forces INIT with sweep index = 1.
- INIT: each cycle drive write enable=1, address=index, data=0, then increment the index. After writing 31, go to RUN. o_busy=1 throughout INIT. Data inputs are ignored.
- RUN, capture condition: i_enable & i_valid.
  - Next cycle: o_control_write_reg = i_RegWrite & (i_reg_write != 0).
  - o_reg_write = i_reg_write.
  - o_data_write per the selection rules below.
- Data selection priority: i_link > i_MemtoReg > ALU.
  - Link: zero-extend i_pc_link to 32 bits.
  - ALU: i_alu_result.
- Load alignment (little-endian lanes, offset = i_alu_result[1:0]):
  - LB/LBU: byte lane = offset, bits [8*offset+7 : 8*offset]; LB sign-extends, LBU zero-extends.
  - LH/LHU: half = offset[1]; offset[0] is ignored (no misalignment trap); LH sign-extends, LHU zero-extends.
  - LW: whole word.
- Non-capture cycles (i_enable=0, or i_valid=0): o_control_write_reg=0. o_reg_write and o_data_write hold their last values, so a held instruction is never written twice.
- o_retired_count: +1 per capture, HALT included; wraps from 0xFFFFFFFF to 0.
- HALT: a captured instruction with i_halt=1 still performs its own write, if any. On the same edge the state moves to HALTED.
- HALTED: o_halted=1, write enable held at 0, inputs ignored, counter frozen. Only reset exits.
- Reset in any state, including mid-sweep, restarts INIT from index 1 and zeroes the counter.

## Timing
- Reset values:
  - o_control_write_reg=0, o_reg_write=0, o_data_write=0, o_retired_count=0, o_halted=0.
  - o_busy=1, since INIT is entered on reset.
- INIT lasts exactly 31 cycles after reset deassertion. o_busy falls in the cycle after register 31's write cycle. The first RUN capture can occur on that edge.
- Write-back latency is 1 cycle: the capture edge is N, and outputs are valid through cycle N+1. The register file commits at edge N+2's launch, i.e. on edge N+1.
- o_retired_count updates on the capture edge and is visible in cycle N+1.
- o_halted rises in cycle N+1 after the HALT capture, together with HALT's write pulse.
- Back-to-back captures produce one write per cycle with no bubble.

## Test plan
- Reset release → 31 consecutive writes, addr 1..31, data 0; o_busy=1 for 31 cycles then 0; o_retired_count=0.
- RUN: ALU write to r5 with i_alu_result=0x1234_5678 → one cycle with write enable=1, addr 5, data 0x12345678; count=1. Same instruction to r0 → enable stays 0, count=2.
- Loads with i_mem_data=0x80FF_7F01:
  - LB offset 3 → 0xFFFFFF80
  - LBU offset 3 → 0x00000080
  - LH offset 2 → 0xFFFF80FF
  - LHU offset 0 → 0x00007F01
  - LW → 0x80FF7F01
- Link priority: i_link=1 and i_MemtoReg=1, i_pc_link=0x7FF, dest r31 → data 0x000007FF.
- Stall/bubble: valid instruction then i_enable=0 for 3 cycles → exactly one write pulse, count +1. i_valid=0 with i_enable=1 → no write, count unchanged.
- HALT with i_RegWrite=1 → its write occurs and o_halted=1 in the same cycle; later valid inputs produce no writes and the count stays fixed. Reset asserted mid-INIT at index 10 → sweep restarts at 1 and o_halted=0.
